// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: opcodes, bubble encoding, PC width and
// the fetch-stage state enum.
package cpu_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BGT  = 4'b0100;
  localparam logic [3:0] OP_BLT  = 4'b0101;
  localparam logic [3:0] OP_ALU  = 4'b1111;

  // ALU opcode with function 0000 writes nothing; 16'h0000 would decode as halt
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'hF000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_target_gen.sv
// Redirect target: IF/ID PC plus the sign-extended, halfword-scaled
// 4-bit branch or 12-bit jump offset, modulo 2^PC_W.
module pc_target_gen
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] if_id_pc_i,
  input  logic [11:0]     if_id_imm_i,
  input  logic            b_jmp_i,
  output logic [PC_W-1:0] target_o
);

  logic [PC_W-1:0] offset_c;

  always_comb begin
    offset_c = '0;
    if (b_jmp_i) begin
      offset_c = {{(PC_W-4){if_id_imm_i[3]}}, if_id_imm_i[3:0]};
    end else begin
      offset_c = {{(PC_W-12){if_id_imm_i[11]}}, if_id_imm_i};
    end
    target_o = if_id_pc_i + (offset_c << 1);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID pipeline register and the
// run/halted/fault state machine that freezes the core.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               pc_op,
  input  logic               b_jmp,
  input  logic               if_flush,
  input  logic               halt,
  input  logic               overflow_error_warning,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               halted,
  output logic               fault,
  output logic [15:0]        fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ifpc_q, ifpc_d;
  logic               valid_q, valid_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [PC_W-1:0]    target_c;
  logic [PC_W-1:0]    pc_inc_c;

  pc_target_gen u_target (
    .if_id_pc_i  (ifpc_q),
    .if_id_imm_i (instr_q[11:0]),
    .b_jmp_i     (b_jmp),
    .target_o    (target_c)
  );

  assign pc_inc_c = pc_q + PC_W'(2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and per-edge fetch priority: halt/fault, redirect, flush, stall, fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (overflow_error_warning || halt) begin
          state_d = overflow_error_warning ? FAULT : HALTED;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (pc_op) begin
          pc_d    = target_c;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (if_flush) begin
          pc_d    = pc_inc_c;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_d    = pc_inc_c;
          instr_d = imem_rdata;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 16'(1);
        end
      end
      default: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q != RUN);
  assign fault       = (state_q == FAULT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirects,
// PC wrap, flush, halt/fault freeze and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_rdata;
  logic        stall, pc_op, b_jmp, if_flush, halt, ovf;
  logic [15:0] imem_addr, if_id_instr, if_id_pc, fetch_count;
  logic        if_id_valid, halted, fault;

  logic [15:0] mem [0:127];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[7:1]];

  fetch_unit dut (
    .clk                    (clk),
    .reset                  (reset),
    .imem_rdata             (imem_rdata),
    .stall                  (stall),
    .pc_op                  (pc_op),
    .b_jmp                  (b_jmp),
    .if_flush               (if_flush),
    .halt                   (halt),
    .overflow_error_warning (ovf),
    .imem_addr              (imem_addr),
    .if_id_instr            (if_id_instr),
    .if_id_pc               (if_id_pc),
    .if_id_valid            (if_id_valid),
    .halted                 (halted),
    .fault                  (fault),
    .fetch_count            (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; pc_op = 0; b_jmp = 0; if_flush = 0; halt = 0; ovf = 0;
  endtask

  // Reset pulse placed between clock edges
  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".addr"},  32'(imem_addr),   32'h0000);
    chk({tag, ".instr"}, 32'(if_id_instr), 32'hF000);
    chk({tag, ".ifpc"},  32'(if_id_pc),    32'h0000);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'h0);
    chk({tag, ".halt"},  32'(halted),      32'h0);
    chk({tag, ".fault"}, 32'(fault),       32'h0);
    chk({tag, ".cnt"},   32'(fetch_count), 32'h0000);
  endtask

  initial begin
    logic [15:0] seq [0:3];
    seq[0] = 16'h1123; seq[1] = 16'h2234; seq[2] = 16'hF108; seq[3] = 16'hC345;
    for (int i = 0; i < 128; i++) mem[i] = 16'hA000 + 16'(i);
    for (int i = 0; i < 4; i++) mem[i] = seq[i];
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk_reset_state("rst");
    reset = 1'b0;

    // Free-running fetch of four words
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("seq%0d.addr", k),  32'(imem_addr),   32'(2 * k));
      chk($sformatf("seq%0d.instr", k), 32'(if_id_instr), 32'(seq[k-1]));
      chk($sformatf("seq%0d.ifpc", k),  32'(if_id_pc),    32'(2 * (k - 1)));
      chk($sformatf("seq%0d.valid", k), 32'(if_id_valid), 32'h1);
    end
    chk("seq.cnt", 32'(fetch_count), 32'd4);

    // Three-cycle stall holds everything
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.addr",  32'(imem_addr),   32'h0008);
      chk("stall.instr", 32'(if_id_instr), 32'hC345);
      chk("stall.ifpc",  32'(if_id_pc),    32'h0006);
      chk("stall.cnt",   32'(fetch_count), 32'd4);
    end
    stall = 0;
    tick();
    chk("unstall.addr",  32'(imem_addr),   32'h000A);
    chk("unstall.instr", 32'(if_id_instr), 32'hA004);
    chk("unstall.ifpc",  32'(if_id_pc),    32'h0008);
    chk("unstall.cnt",   32'(fetch_count), 32'd5);

    // Fetch up to a beq -2 at 0x10, then redirect with flush and stall asserted
    mem[8] = 16'h6FFE;
    for (int k = 0; k < 4; k++) tick();
    chk("beq.setup.instr", 32'(if_id_instr), 32'h6FFE);
    chk("beq.setup.ifpc",  32'(if_id_pc),    32'h0010);
    pc_op = 1; b_jmp = 1; if_flush = 1; stall = 1;
    tick();
    idle_inputs();
    chk("beq.addr",  32'(imem_addr),   32'h000C);
    chk("beq.instr", 32'(if_id_instr), 32'hF000);
    chk("beq.valid", 32'(if_id_valid), 32'h0);
    chk("beq.cnt",   32'(fetch_count), 32'd9);

    // jmp -2048 words from 0x0004 wraps to 0xF004
    pulse_reset();
    chk_reset_state("rst2");
    mem[2] = 16'h7800;
    for (int k = 0; k < 3; k++) tick();
    chk("jmp.setup.instr", 32'(if_id_instr), 32'h7800);
    chk("jmp.setup.ifpc",  32'(if_id_pc),    32'h0004);
    pc_op = 1; b_jmp = 0;
    tick();
    idle_inputs();
    chk("jmp.addr",  32'(imem_addr),   32'hF004);
    chk("jmp.valid", 32'(if_id_valid), 32'h0);

    // Backward branch from 0 lands at 0xFFFC; sequential fetch wraps to 0
    pulse_reset();
    mem[0] = 16'h6FFE;
    mem[127] = 16'h1234;
    tick();
    pc_op = 1; b_jmp = 1;
    tick();
    idle_inputs();
    chk("wrapbr.addr", 32'(imem_addr), 32'hFFFC);
    tick();
    tick();
    chk("wrap.addr",  32'(imem_addr),   32'h0000);
    chk("wrap.instr", 32'(if_id_instr), 32'h1234);
    chk("wrap.ifpc",  32'(if_id_pc),    32'hFFFE);
    chk("wrap.cnt",   32'(fetch_count), 32'd3);

    // Halt freezes the core; later requests are ignored
    halt = 1;
    tick();
    idle_inputs();
    chk("halt.halted", 32'(halted),      32'h1);
    chk("halt.fault",  32'(fault),       32'h0);
    chk("halt.addr",   32'(imem_addr),   32'h0000);
    chk("halt.instr",  32'(if_id_instr), 32'hF000);
    chk("halt.valid",  32'(if_id_valid), 32'h0);
    pc_op = 1; b_jmp = 1; ovf = 1;
    tick();
    tick();
    idle_inputs();
    chk("frozen.addr",  32'(imem_addr),   32'h0000);
    chk("frozen.cnt",   32'(fetch_count), 32'd3);
    chk("frozen.fault", 32'(fault),       32'h0);
    chk("frozen.halt",  32'(halted),      32'h1);
    pulse_reset();
    chk_reset_state("rst3");

    // Flush alone advances PC and inserts a bubble
    tick();
    tick();
    if_flush = 1;
    tick();
    idle_inputs();
    chk("flush.addr",  32'(imem_addr),   32'h0006);
    chk("flush.instr", 32'(if_id_instr), 32'hF000);
    chk("flush.valid", 32'(if_id_valid), 32'h0);
    chk("flush.cnt",   32'(fetch_count), 32'd2);

    // Overflow wins over halt
    ovf = 1; halt = 1;
    tick();
    idle_inputs();
    chk("fault.fault",  32'(fault),     32'h1);
    chk("fault.halted", 32'(halted),    32'h1);
    chk("fault.addr",   32'(imem_addr), 32'h0006);

    // Asynchronous reset takes effect before the next edge
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async");
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
